// File: rtl/execute_div_pkg.sv
// Shared types and constants for the execute-stage iterative divider.
package execute_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; only signed operands with the MSB set get negated.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/execute_div_if.sv
// Pipeline <-> divider connection: operands, start/flush/hold controls and results.
interface execute_div_if;
  import execute_div_pkg::*;

  // start_i is level-held while the instruction sits in E and is only acted on
  // in IDLE; valid_o alone qualifies quot_o/rem_o, and hold_i keeps a finished
  // result presented; stall_o asks the hazard unit to freeze E.
  logic              start_i;
  logic              signed_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic              flush_i;
  logic              hold_i;
  logic              stall_o;
  logic              valid_o;
  logic [DATA_W-1:0] quot_o;
  logic [DATA_W-1:0] rem_o;
  div_state_e        state_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, flush_i, hold_i,
    input  stall_o, valid_o, quot_o, rem_o, state_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, flush_i, hold_i,
    output stall_o, valid_o, quot_o, rem_o, state_o
  );

endinterface

// File: rtl/execute_div_div_step.sv
// One restoring-division iteration: shift {r,q} left, subtract divisor if it fits.
module div_step
  import execute_div_pkg::*;
(
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quot,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quot
);

  logic [DATA_W:0] w_shifted;
  logic [DATA_W:0] w_trial;
  logic            w_neg;

  assign w_shifted = {i_rem, i_quot[DATA_W-1]};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  // A shifted value with its top bit set always exceeds the divisor.
  assign w_neg     = ~w_shifted[DATA_W] & w_trial[DATA_W];

  assign o_rem  = w_neg ? w_shifted[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign o_quot = {i_quot[DATA_W-2:0], ~w_neg};

endmodule

// File: rtl/execute_div.sv
// Iterative 32-cycle restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
module execute_div
  import execute_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  execute_div_if.slave  div_bus
);

  div_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_part;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_div;
  logic              r_qsign;
  logic              r_rsign;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic              r_valid;

  logic [DATA_W-1:0] w_part_next;
  logic [DATA_W-1:0] w_q_next;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == IDLE) & div_bus.start_i & ~div_bus.flush_i;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  assign div_bus.stall_o = w_accept | (r_state == CALC);
  assign div_bus.valid_o = r_valid;
  assign div_bus.quot_o  = r_quot;
  assign div_bus.rem_o   = r_rem;
  assign div_bus.state_o = r_state;

  div_step u_step (
    .i_rem     (r_part),
    .i_quot    (r_q),
    .i_divisor (r_div),
    .o_rem     (w_part_next),
    .o_quot    (w_q_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_part  <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else if (div_bus.flush_i) begin
      // A flushed operation is dropped; the last committed result stays put.
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_bus.start_i) begin
            if (div_bus.opb_i == '0) begin
              r_quot  <= DIV0_QUOT;
              r_rem   <= div_bus.opa_i;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_part  <= '0;
              r_q     <= abs_val(div_bus.opa_i, div_bus.signed_i);
              r_div   <= abs_val(div_bus.opb_i, div_bus.signed_i);
              r_qsign <= div_bus.signed_i &
                         (div_bus.opa_i[DATA_W-1] ^ div_bus.opb_i[DATA_W-1]);
              r_rsign <= div_bus.signed_i & div_bus.opa_i[DATA_W-1];
              r_cnt   <= '0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_part <= w_part_next;
          r_q    <= w_q_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_quot  <= cond_neg(w_q_next, r_qsign);
            r_rem   <= cond_neg(w_part_next, r_rsign);
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // start_i is still high for the same instruction here, so it is ignored.
          if (!div_bus.hold_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_div.sv
// Self-checking bench for execute_div: directed corner cases plus randomized DIV/DIVU traffic.
module tb_execute_div;
  import execute_div_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  execute_div_if bus ();

  execute_div dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [31:0] last_quot = '0;
  logic [31:0] last_rem  = '0;
  int          st_lo = -1, st_hi = -2;
  int          vl_lo = -1, vl_hi = -2;
  bit          chk_en = 1'b0;
  bit          e_stall, e_valid;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {quotient, remainder} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      e_stall = (cyc >= st_lo) && (cyc <= st_hi);
      e_valid = (cyc >= vl_lo) && (cyc <= vl_hi);
      check("stall_o", 64'(bus.stall_o), 64'(e_stall));
      check("valid_o", 64'(bus.valid_o), 64'(e_valid));
      if (e_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          check("quot_o", 64'(bus.quot_o), 64'(exp_q[0][63:32]));
          check("rem_o", 64'(bus.rem_o), 64'(exp_q[0][31:0]));
          if (cyc == vl_hi) begin
            last_quot = exp_q[0][63:32];
            last_rem  = exp_q[0][31:0];
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("quot_held", 64'(bus.quot_o), 64'(last_quot));
        check("rem_held", 64'(bus.rem_o), 64'(last_rem));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.start_i = 1'b0;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    bus.opa_i   = $urandom;
    bus.opb_i   = $urandom;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one divide, hold start_i through DONE, hold the result for 'hold' extra cycles.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold, input logic [63:0] exp);
    int lat;
    lat = (b == 32'h0) ? 1 : 33;
    bus.start_i  = 1'b1;
    bus.signed_i = s;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.flush_i  = 1'b0;
    bus.hold_i   = 1'b0;
    st_lo = cyc;
    st_hi = cyc + lat - 1;
    vl_lo = cyc + lat;
    vl_hi = cyc + lat + hold;
    exp_q.push_back(exp);
    repeat (lat) begin @(posedge clk); #1; end
    repeat (hold) begin bus.hold_i = 1'b1; @(posedge clk); #1; end
    bus.hold_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic flush_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.start_i  = 1'b1;
    bus.flush_i  = 1'b1;
    bus.signed_i = s;
    bus.opa_i    = a;
    bus.opb_i    = b;
    st_lo = -1; st_hi = -2; vl_lo = -1; vl_hi = -2;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic flush_mid(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int k);
    bus.start_i  = 1'b1;
    bus.signed_i = s;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.flush_i  = 1'b0;
    st_lo = cyc; st_hi = cyc + k; vl_lo = -1; vl_hi = -2;
    repeat (k) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b);
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = a;
    bus.opb_i    = b;
    st_lo = cyc; st_hi = cyc + 32; vl_lo = -1; vl_hi = -2;
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk);
    #2;
    chk_en      = 1'b0;
    bus.start_i = 1'b0;
    rst         = 1'b0;
    #1;
    check("rst_async_valid", 64'(bus.valid_o), 64'd0);
    check("rst_async_stall", 64'(bus.stall_o), 64'd0);
    check("rst_async_quot", 64'(bus.quot_o), 64'd0);
    check("rst_async_rem", 64'(bus.rem_o), 64'd0);
    check("rst_async_state", 64'(bus.state_o), 64'(IDLE));
    last_quot = '0;
    last_rem  = '0;
    st_lo = -1; st_hi = -2;
    @(posedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b;
    logic        s;
    int          mode;

    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.opa_i = '0; bus.opb_i = '0;
    bus.flush_i = 1'b0; bus.hold_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(bus.valid_o), 64'd0);
    check("reset_stall", 64'(bus.stall_o), 64'd0);
    check("reset_quot", 64'(bus.quot_o), 64'd0);
    check("reset_rem", 64'(bus.rem_o), 64'd0);
    check("reset_state", 64'(bus.state_o), 64'(IDLE));
    @(posedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    // Hand-computed values pin the reference model.
    check("model_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd14, 32'd2});
    check("model_div_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    check("model_div_7_m2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), {32'hFFFF_FFFD, 32'd1});
    check("model_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h8000_0000, 32'd0});
    check("model_divu_5_0", ref_div(32'd5, 32'd0, 1'b0), {32'hFFFF_FFFF, 32'd5});

    // Directed corner cases with literal expectations.
    drive_op(32'd100, 32'd7, 1'b0, 0, {32'd14, 32'd2});
    drive_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    drive_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, {32'hFFFF_FFFD, 32'd1});
    idle(1);
    drive_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, {32'h8000_0000, 32'd0});
    drive_op(32'd5, 32'd0, 1'b0, 0, {32'hFFFF_FFFF, 32'd5});
    drive_op(32'd1000, 32'd10, 1'b0, 3, {32'd100, 32'd0});
    drive_op(32'hFFFF_FFFF, 32'd3, 1'b0, 0, {32'h5555_5555, 32'd0});
    idle(2);
    drive_op(32'hFFFF_FFFB, 32'd0, 1'b1, 2, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
    flush_mid(32'd12345, 32'd67, 1'b0, 10);
    idle(3);
    flush_start(32'd77, 32'd3, 1'b0);
    idle(1);
    flush_start(32'd9, 32'd0, 1'b1);
    idle(2);
    drive_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
    reset_mid(32'd5000, 32'd9);
    idle(2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      case (mode)
        0: b = 32'($urandom_range(1, 20));
        1: b = 32'h0;
        2: b = -32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 50));
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      drive_op(a, b, s, $urandom_range(0, 2), ref_div(a, b, s));
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
